hc_prefix_subtractor_pipe: RTL and testbench
============================================

Name: hc_prefix_subtractor_pipe

Overview:
- Pipelined parallel-prefix subtractor: D = A − B − Bin, with borrow-out.
- It is the subtract-direction companion to the Han-Carlson adder and uses the same sparse (odd-bit) prefix network on A + ~B + ~Bin.
- Three register stages with an elastic valid/ready handshake on both sides.
- Sits between operand-producing logic and result consumers in datapaths that need both add and subtract at full throughput.

Parameters:
- WIDTH, 16, operand and result width in bits; legal values are powers of two from 4 to 64.
- VALENCY, 2, prefix-cell valency; only 2 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  block can accept operands this cycle.
- A  input  [WIDTH:1]  minuend.
- B  input  [WIDTH:1]  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- D  output  [WIDTH:1]  difference, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 when unsigned A < B + Bin.
- ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready on a clk edge.
  - An output transfer occurs when out_valid && out_ready.
- Arithmetic:
  - Internally Cin = ~Bin, B' = ~B.
  - Bitwise G = A & B', P = A ^ B'; bit 0 carries G0 = Cin, P0 = 0.
  - D = P ^ carry-into-bit; Bout = ~carry-out(WIDTH).
- Pipeline stages:
  - S1 registers G, P [WIDTH:0] and A[WIDTH], B[WIDTH] for the overflow computation.
  - S2 registers the odd-position group generates after Kogge-Stone-style levels (log2 WIDTH levels on odd bits).
  - S3 registers the even-bit fix-up, the sum, Bout and ovf.
  - D, Bout and ovf are driven directly from S3 registers.
- Latency: 3 cycles from input transfer to out_valid with no stall.
- Throughput: 1 result per cycle while out_ready = 1.
- Stage-valid bits v1, v2, v3:
  - Stage k loads when it is empty or its contents advance this cycle.
  - in_ready = ~v1 | adv1, where adv1 = v1 & (~v2 | adv2) and adv2 = v2 & (~v3 | out_ready).
  - in_ready is purely combinational from the valid bits and out_ready; it has no combinational path from in_valid.
- Stall:
  - When out_ready = 0, S3 holds D, Bout and ovf stable while out_valid = 1.
  - Upstream stages fill, so at most 3 transactions are held.
  - in_ready deasserts only when all of v1, v2, v3 = 1 and out_ready = 0.
- Data registers load only on a stage load. Bubbles never corrupt held data.
- Ordering: results are delivered strictly in input order, with none dropped or duplicated.
- Reset:
  - rst = 1 clears v1, v2, v3 at the next edge and discards any in-flight data.
  - During reset and after it: out_valid = 0, in_ready = 1, D = 0, Bout = 0, ovf = 0.
  - An input presented in the same cycle as rst is not accepted.
- Simultaneous in/out transfer on a full pipe: S3 drains, all stages shift, and the new operand enters S1 in the same cycle.

Optional Feature:
- Macro: HC_SUB_OVF_FLAG_EN.
- When defined:
  - S3 computes ovf = (A[WIDTH] ^ B[WIDTH]) & (A[WIDTH] ^ D[WIDTH]), i.e. two's-complement overflow of A − B − Bin.
  - ovf is held stable during a stall, like D.
- When undefined:
  - ovf is tied to 0.
  - The S1 sign-bit registers are not instantiated.
  - The port list is unchanged.

Test Plan:
- No-stall latency, WIDTH = 16, out_ready = 1: A = 0x0005, B = 0x0003, Bin = 0 → exactly 3 cycles later out_valid = 1, D = 0x0002, Bout = 0.
- Wrap-around borrow: A = 0x0000, B = 0x0001, Bin = 0 → D = 0xFFFF, Bout = 1. Also A = 0x0010, B = 0x0010, Bin = 1 → D = 0xFFFF, Bout = 1.
- Signed overflow: A = 0x8000, B = 0x0001 → D = 0x7FFF, Bout = 0, and ovf = 1 with HC_SUB_OVF_FLAG_EN, 0 without. Also A = 0x7FFF, B = 0xFFFF → D = 0x8000, Bout = 1, ovf = 1 (macro on).
- Back-to-back streaming, out_ready = 1: stream 8 random operand pairs on consecutive cycles → 8 consecutive out_valid cycles, in order, matching the reference model.
- Backpressure: hold out_ready = 0 and offer 5 pairs back-to-back → 3 are accepted, then in_ready = 0 and D stays stable. Release out_ready → all 5 results emerge in order with no loss.
- Reset mid-operation: with 3 transactions in flight, assert rst for 1 cycle → next cycle out_valid = 0, in_ready = 1, D = 0. A new input then yields a correct result after 3 cycles, and no stale results appear.

Source files
------------

// File: rtl/hc_prefix_subtractor_pipe.sv
// Pipelined Han-Carlson subtractor: D = A - B - Bin, Bout, ovf.
// Ports: clk, rst, in_valid/in_ready, A, B, Bin, out_valid/out_ready,
//   D, Bout, ovf. Macro HC_SUB_OVF_FLAG_EN enables the ovf flag.
module hc_prefix_subtractor_pipe #(
    parameter int WIDTH   = 16,
    parameter int VALENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:1] A,
    input  logic [WIDTH:1] B,
    input  logic           Bin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:1] D,
    output logic           Bout,
    output logic           ovf
);

    localparam int NP = WIDTH / VALENCY;
    localparam int LV = $clog2(NP);

    logic v1, v2, v3;
    logic adv1, adv2, load1;

    logic [WIDTH:0] g_in, p_in;
    logic [WIDTH:0] s1_g, s1_p;

    logic [NP-1:0]  kg, kp;
    logic [NP-1:0]  s2_gg;
    logic [NP:0]    s2_ge;
    logic [WIDTH:1] s2_p;

    logic [WIDTH:0] c;
    logic [WIDTH:1] d_nx;
    logic           bout_nx;

    logic [WIDTH:1] d_q;
    logic           bout_q;

    // Handshake: a stage may load when empty or when it drains.
    assign adv2     = v2 & (~v3 | out_ready);
    assign adv1     = v1 & (~v2 | adv2);
    assign in_ready = ~v1 | adv1;
    assign load1    = in_valid & in_ready;

    // Subtract as A + ~B + ~Bin; bit 0 carries the inverted borrow-in.
    assign g_in = {A & ~B, ~Bin};
    assign p_in = {A ^ ~B, 1'b0};

    // Sparse prefix: pair (2j+1, 2j), then Kogge-Stone over pairs.
    // Pair 0 spans bit 0 whose P is 0, so shifted-in zeros are safe.
    always_comb begin
        kg = '0;
        kp = '0;
        for (int j = 0; j < NP; j++) begin
            kg[j] = s1_g[2*j+1] | (s1_p[2*j+1] & s1_g[2*j]);
            kp[j] = s1_p[2*j+1] & s1_p[2*j];
        end
        for (int k = 0; k < LV; k++) begin
            kg = kg | (kp & (kg << (1 << k)));
            kp = kp & (kp << (1 << k));
        end
    end

    // Even positions get their group generate from the odd one below.
    always_comb begin
        c    = '0;
        c[0] = s2_ge[0];
        for (int j = 0; j < NP; j++)
            c[2*j+1] = s2_gg[j];
        for (int j = 1; j <= NP; j++)
            c[2*j] = s2_ge[j] | (s2_p[2*j] & s2_gg[j-1]);
        d_nx    = s2_p ^ c[WIDTH-1:0];
        bout_nx = ~c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            if (load1)     v1 <= 1'b1;
            else if (adv1) v1 <= 1'b0;
            if (adv1)      v2 <= 1'b1;
            else if (adv2) v2 <= 1'b0;
            if (adv2)           v3 <= 1'b1;
            else if (out_ready) v3 <= 1'b0;
            if (adv2) begin
                d_q    <= d_nx;
                bout_q <= bout_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load1) begin
            s1_g <= g_in;
            s1_p <= p_in;
        end
        if (adv1) begin
            s2_gg <= kg;
            s2_p  <= s1_p[WIDTH:1];
            for (int j = 0; j <= NP; j++)
                s2_ge[j] <= s1_g[2*j];
        end
    end

`ifdef HC_SUB_OVF_FLAG_EN
    logic s1_as, s1_bs, s2_as, s2_bs, ovf_q;

    always_ff @(posedge clk) begin
        if (load1) begin
            s1_as <= A[WIDTH];
            s1_bs <= B[WIDTH];
        end
        if (adv1) begin
            s2_as <= s1_as;
            s2_bs <= s1_bs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (adv2)
            ovf_q <= (s2_as ^ s2_bs) & (s2_as ^ d_nx[WIDTH]);
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = v3;
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_hc_prefix_subtractor_pipe.sv
// Self-checking bench for hc_prefix_subtractor_pipe (WIDTH = 16).
// Table vectors, streaming, backpressure, reset and random traffic.
module tb_hc_prefix_subtractor_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:1]   A;
    logic [W:1]   B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W:1]   D;
    logic         Bout;
    logic         ovf;

    hc_prefix_subtractor_pipe #(.WIDTH(W), .VALENCY(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .Bout(Bout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf_on;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    int   nout     = 0;
    res_t sb[$];

`ifdef HC_SUB_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic with an extra top bit.
    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bin);
        res_t r;
        logic [W:0] diff;
        int sa, sb2, sd;
        diff   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        r.d    = diff[W-1:0];
        r.bout = diff[W];
        sa     = $signed(a);
        sb2    = $signed(b);
        sd     = sa - sb2 - int'(bin);
        r.ovf  = OVF_EN && (sd > 32767 || sd < -32768);
        return r;
    endfunction

    // Scoreboard: inputs accepted in order, results compared in order.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                nout++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_d", 32'(D), 32'(e.d));
                    chk("sb_bout", 32'(Bout), 32'(e.bout));
                    chk("sb_ovf", 32'(ovf), 32'(e.ovf));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(A, B, Bin));
        end
    end

    vec_t tbl[9];

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic got;
        logic [W-1:0] dg;
        logic bg, og;
        @(posedge clk);
        #1;
        A = v.a; B = v.b; Bin = v.bin;
        in_valid = 1'b1;
        lat = 99; got = 1'b0;
        dg = '0; bg = 1'b0; og = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1; lat = n;
                dg = D; bg = Bout; og = ovf;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_d"}, 32'(dg), 32'(v.d));
        chk({tag, "_bout"}, 32'(bg), 32'(v.bout));
        chk({tag, "_ovf"}, 32'(og), 32'(OVF_EN & v.ovf_on));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bpa[5];
        logic [W-1:0] bpb[5];
        logic [13:0]  ov;
        logic [W-1:0] dsnap;
        int k, n0;

        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[8] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Bin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_d", 32'(D), 0);
        chk("rst_bout", 32'(Bout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Streaming: 8 back-to-back inputs, expect 8 consecutive outputs.
        ov = '0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            in_valid = (c < 8);
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            @(negedge clk);
            ov[c] = out_valid;
        end
        chk("stream_pattern", 32'(ov), 32'h07F8);

        // Backpressure: only three fit while the output is blocked.
        for (int i = 0; i < 5; i++) begin
            bpa[i] = W'($urandom);
            bpb[i] = W'($urandom);
        end
        k = 0; dsnap = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid = (k < 5);
            A = bpa[k % 5]; B = bpb[k % 5]; Bin = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            if (c == 3) dsnap = D;
        end
        chk("bp_accepted", k, 3);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_d_stable", 32'(D), 32'(dsnap));
        n0 = nout;
        for (int c = 0; c < 30 && (nout - n0) < 5; c++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid = (k < 5);
            A = bpa[k % 5]; B = bpb[k % 5]; Bin = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) k++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", nout - n0, 5);

        // Reset with three in flight; an input beside rst is dropped.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid = 1'b1;
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        A = 16'h4444; B = 16'h1111;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        chk("mrst_d", 32'(D), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mrst_no_stale", 32'(out_valid), 0);
        end
        run_vec(tbl[3], "post_rst");

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            if (c % 50 == 0) begin
                A = 16'h8000; B = 16'h7FFF;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
